// File: rtl/rle_decompressor_pkg.sv
// Shared record-format definitions for the UART video link RLE path.
// The row compressor imports this same package.
package rle_pkg;

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_HI    = 2'd1,
    S_LO    = 2'd2,
    S_EMIT  = 2'd3
  } rle_state_t;

  localparam logic [7:0] SYNC_CODE       = 8'h00;
  localparam int         MAX_RUN         = 255;
  localparam int         BYTES_PER_PIXEL = 2;

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int PIX_W = BYTES_PER_PIXEL * 8;

endpackage

// File: rtl/rle_decompressor_if.sv
// Byte-in / pixel-out handshake bundle of the RLE decompressor.
// master: the environment (UART receiver + frame-buffer writer side).
// slave:  the decompressor.
interface rle_decompressor_if
  import rle_pkg::*;
#(
  parameter int PixelBitWidth = PIX_W
);
  logic [7:0]               i_byte;
  logic                     i_valid;
  logic                     o_ready;
  logic [PixelBitWidth-1:0] o_pixel;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_row_end;
  logic                     o_err;

  modport master (
    output i_byte, i_valid, i_ready,
    input  o_ready, o_pixel, o_valid, o_row_end, o_err
  );

  modport slave (
    input  i_byte, i_valid, i_ready,
    output o_ready, o_pixel, o_valid, o_row_end, o_err
  );
endinterface

// File: rtl/rle_decompressor.sv
// Expands COUNT/PIX_HI/PIX_LO run records into individual pixels, tracks the
// row column, and resynchronises on row-sync markers.
//
// state   | meaning
// S_COUNT | wait for run length byte; 0x00 is a row-sync marker
// S_HI    | wait for pixel high byte (0x00 is plain data)
// S_LO    | wait for pixel low byte; pixel goes valid next cycle
// S_EMIT  | present pixel, one per handshake until run ends or row overflows
module rle_decompressor
  import rle_pkg::*;
#(
  parameter int RowPixelWidth = 640,
  parameter int PixelBitWidth = 16
) (
  input  logic              CLK,
  input  logic              RST,
  rle_decompressor_if.slave bus
);

  localparam int ColW = (RowPixelWidth > 1) ? $clog2(RowPixelWidth) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(RowPixelWidth - 1);

  rle_state_t               state_q, state_d;
  logic [RUN_W-1:0]         run_left_q, run_left_d;
  logic [ColW-1:0]          col_q, col_d;
  logic [7:0]               pix_hi_q, pix_hi_d;
  logic [PixelBitWidth-1:0] pixel_q, pixel_d;
  logic                     valid_q, valid_d;
  logic                     row_end_q, row_end_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;
  logic                     accept;

  assign accept = bus.i_valid && ready_q;

  // Next-state decode for the FSM, run/column counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    run_left_d = run_left_q;
    col_d      = col_q;
    pix_hi_d   = pix_hi_q;
    pixel_d    = pixel_q;
    valid_d    = valid_q;
    row_end_d  = row_end_q;
    err_d      = 1'b0;
    ready_d    = ready_q;
    unique case (state_q)
      S_COUNT: begin
        ready_d = 1'b1;
        if (accept) begin
          if (bus.i_byte == SYNC_CODE) begin
            // Sync mid-row abandons the partial row without padding.
            if (col_q != '0) begin
              err_d = 1'b1;
              col_d = '0;
            end
          end else begin
            run_left_d = bus.i_byte;
            state_d    = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          pix_hi_d = bus.i_byte;
          state_d  = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          pixel_d   = {pix_hi_q, bus.i_byte};
          valid_d   = 1'b1;
          row_end_d = (col_q == ColLast);
          ready_d   = 1'b0;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.i_ready) begin
          if (run_left_q == RUN_W'(1)) begin
            // Run ends here; ending exactly on the row end is legal.
            run_left_d = '0;
            col_d      = (col_q == ColLast) ? '0 : col_q + ColW'(1);
            valid_d    = 1'b0;
            row_end_d  = 1'b0;
            ready_d    = 1'b1;
            state_d    = S_COUNT;
          end else if (col_q == ColLast) begin
            // Run spills past the row end: truncate and flag.
            run_left_d = '0;
            col_d      = '0;
            valid_d    = 1'b0;
            row_end_d  = 1'b0;
            ready_d    = 1'b1;
            err_d      = 1'b1;
            state_d    = S_COUNT;
          end else begin
            run_left_d = run_left_q - RUN_W'(1);
            col_d      = col_q + ColW'(1);
            row_end_d  = ((col_q + ColW'(1)) == ColLast);
          end
        end
      end
      default: state_d = S_COUNT;
    endcase
  end

  // State and output registers; reset aborts any run in progress silently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_COUNT;
      run_left_q <= '0;
      col_q      <= '0;
      pix_hi_q   <= '0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      row_end_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_left_q <= run_left_d;
      col_q      <= col_d;
      pix_hi_q   <= pix_hi_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      row_end_q  <= row_end_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_pixel   = pixel_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_row_end = row_end_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_rle_decompressor.sv
// Directed bench for rle_decompressor with a pixel scoreboard and error-pulse monitor.
module tb_rle_decompressor;
  import rle_pkg::*;

  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  rle_decompressor_if #(.PixelBitWidth(16)) bus ();

  rle_decompressor #(.RowPixelWidth(W), .PixelBitWidth(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic        row_end;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pix, input logic row_end);
    exp_t e;
    e.pix     = pix;
    e.row_end = row_end;
    exp_q.push_back(e);
  endtask

  // Monitor: scores every pixel handshake and counts error pulses.
  always @(posedge CLK) begin
    exp_t e;
    if (RST) begin
      if (bus.o_err === 1'b1) err_seen++;
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel actual=%0h expected=none", bus.o_pixel);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {16'h0, bus.o_pixel}, {16'h0, e.pix});
          chk("row_end", {31'h0, bus.o_row_end}, {31'h0, e.row_end});
        end
      end
    end
  end

  // Drive one byte and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge CLK);
    bus.i_byte  = b;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK);
      if (bus.o_ready === 1'b1) done = 1'b1;
    end
    #1 bus.i_valid = 1'b0;
    if (!done) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_run(input logic [7:0] cnt, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(cnt);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge CLK);
      #1;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    bus.i_byte  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready",   {31'h0, bus.o_ready},   32'd0);
    chk("rst_valid",   {31'h0, bus.o_valid},   32'd0);
    chk("rst_pixel",   {16'h0, bus.o_pixel},   32'd0);
    chk("rst_row_end", {31'h0, bus.o_row_end}, 32'd0);
    chk("rst_err",     {31'h0, bus.o_err},     32'd0);
    @(negedge CLK) RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("ready_after_reset", {31'h0, bus.o_ready}, 32'd1);

    // Run of 3 at col 0, then latency and handback checks
    push(16'h1234, 1'b0); push(16'h1234, 1'b0); push(16'h1234, 1'b0);
    send_run(8'h03, 8'h12, 8'h34);
    chk("lat_valid", {31'h0, bus.o_valid}, 32'd1);
    chk("lat_pixel", {16'h0, bus.o_pixel}, 32'h1234);
    chk("emit_ready_low", {31'h0, bus.o_ready}, 32'd0);
    wait_drain("t1_drain");
    chk("t1_ready_back", {31'h0, bus.o_ready}, 32'd1);
    chk("t1_valid_low", {31'h0, bus.o_valid}, 32'd0);
    chk("t1_err_count", err_seen, 32'd0);

    // Sync at col 3 -> one-cycle error pulse
    send_byte(8'h00);
    chk("sync_err_pulse", {31'h0, bus.o_err}, 32'd1);
    @(posedge CLK);
    #1;
    chk("sync_err_one_cycle", {31'h0, bus.o_err}, 32'd0);
    chk("sync_err_count", err_seen, 32'd1);

    // Two runs filling one row; 0x00 as pixel data is not sync
    push(16'hABCD, 1'b0); push(16'hABCD, 1'b0);
    push(16'h0001, 1'b0); push(16'h0001, 1'b1);
    send_run(8'h02, 8'hAB, 8'hCD);
    send_run(8'h02, 8'h00, 8'h01);
    wait_drain("t2_drain");
    repeat (2) @(posedge CLK);
    #1 chk("t2_err_count", err_seen, 32'd1);

    // Leading sync at col 0 is silent; run of 6 overflows the row
    send_byte(8'h00);
    chk("sync_col0_no_err", {31'h0, bus.o_err}, 32'd0);
    push(16'h5555, 1'b0); push(16'h5555, 1'b0);
    push(16'h5555, 1'b0); push(16'h5555, 1'b1);
    send_run(8'h06, 8'h55, 8'h55);
    wait_drain("t3_drain");
    chk("ovf_err_pulse", {31'h0, bus.o_err}, 32'd1);
    chk("ovf_ready", {31'h0, bus.o_ready}, 32'd1);
    chk("ovf_valid_low", {31'h0, bus.o_valid}, 32'd0);
    @(posedge CLK);
    #1 chk("ovf_err_count", err_seen, 32'd2);

    // One pixel, sync mid-row, then an exact-fit run from col 0
    push(16'h1111, 1'b0);
    send_run(8'h01, 8'h11, 8'h11);
    wait_drain("t4a_drain");
    chk("t4_no_err_run_end", {31'h0, bus.o_err}, 32'd0);
    send_byte(8'h00);
    chk("t4_sync_err", {31'h0, bus.o_err}, 32'd1);
    push(16'h2222, 1'b0); push(16'h2222, 1'b0);
    push(16'h2222, 1'b0); push(16'h2222, 1'b1);
    send_run(8'h04, 8'h22, 8'h22);
    wait_drain("t4b_drain");
    chk("exact_fit_no_err", {31'h0, bus.o_err}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 chk("t4_err_count", err_seen, 32'd3);

    // Backpressure: i_ready pattern 0,0,1,0,1
    bus.i_ready = 1'b0;
    push(16'h7788, 1'b0); push(16'h7788, 1'b0);
    send_run(8'h02, 8'h77, 8'h88);
    pat = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus.i_ready = pat[i];
      chk("bp_valid", {31'h0, bus.o_valid}, 32'd1);
      chk("bp_pixel", {16'h0, bus.o_pixel}, 32'h7788);
      chk("bp_ready_low", {31'h0, bus.o_ready}, 32'd0);
    end
    @(negedge CLK);
    chk("bp_ready_back", {31'h0, bus.o_ready}, 32'd1);
    chk("bp_valid_low", {31'h0, bus.o_valid}, 32'd0);
    chk("bp_handshakes", exp_q.size(), 32'd0);
    bus.i_ready = 1'b1;

    // Reset mid-run after one of five pixels
    push(16'hABAB, 1'b0);
    send_run(8'h05, 8'hAB, 8'hAB);
    wait_drain("t6_first_pixel");
    RST = 1'b0;
    #1;
    chk("mid_rst_valid",   {31'h0, bus.o_valid},   32'd0);
    chk("mid_rst_ready",   {31'h0, bus.o_ready},   32'd0);
    chk("mid_rst_pixel",   {16'h0, bus.o_pixel},   32'd0);
    chk("mid_rst_row_end", {31'h0, bus.o_row_end}, 32'd0);
    chk("mid_rst_err",     {31'h0, bus.o_err},     32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    push(16'h9999, 1'b0);
    send_run(8'h01, 8'h99, 8'h99);
    wait_drain("t6_drain");
    repeat (2) @(posedge CLK);
    #1 chk("t6_err_count", err_seen, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Receive-side counterpart of the row RLE compressor in the UART video link. Takes the compressed byte stream from the UART receiver and re-expands each run into individual 16-bit pixels. Pixels are handed to the frame-buffer writer with a valid/ready handshake, and row boundaries are flagged. Stream errors are detected and resynchronised on row-sync markers.

## Interface
- RowPixelWidth, 640, pixels per frame row; column counter wraps at this value.
- PixelBitWidth, 16, pixel width; fixed at 16 (two bytes per pixel), other values unsupported.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- i_byte  in  8  compressed byte from UART receiver.
- i_valid  in  1  i_byte valid this cycle.
- o_ready  out  1  decoder accepts i_byte this cycle; byte consumed when i_valid && o_ready.
- o_pixel  out  PixelBitWidth  decoded pixel, held stable while o_valid && !i_ready.
- o_valid  out  1  o_pixel valid.
- i_ready  in  1  downstream accepts pixel; pixel consumed when o_valid && i_ready.
- o_row_end  out  1  qualifies o_pixel as the last pixel of a row (column RowPixelWidth-1).
- o_err  out  1  one-cycle pulse on a stream error.

## Operation
- Stream format is a sequence of records. Run record = COUNT, PIX_HI, PIX_LO. COUNT is 1..255 (run length); pixel is big-endian.
- COUNT = 8'h00 is the row-sync marker (SYNC_CODE). It is a 1-byte record meaning "next pixel starts a new row".
- FSM states:
  - S_COUNT: o_ready=1. Byte 0x00 → sync handling, stay. Nonzero → latch run_left=byte, go to S_HI.
  - S_HI: o_ready=1. Latch pix[15:8], go to S_LO. 0x00 is ordinary data here.
  - S_LO: o_ready=1. Latch pix[7:0], go to S_EMIT.
  - S_EMIT: o_ready=0, o_valid=1. On each pixel handshake: run_left−1 and col+1 (col wraps RowPixelWidth-1 → 0). When the handshake consumes the last pixel of the run, go to S_COUNT.
- Sync handling:
  - col==0: no action, no error.
  - col≠0: o_err pulse, col forced to 0. The partial row is abandoned and no padding pixels are generated.
- Run overflow: if a run extends past column RowPixelWidth-1, the pixel at column RowPixelWidth-1 is emitted with o_row_end=1 and the run is truncated. o_err pulses in the cycle after that handshake, run_left is cleared, col=0, and the state goes to S_COUNT. A run that ends exactly at the row end is legal.
- o_row_end = o_valid && (col == RowPixelWidth-1).
- Widths: run_left 8 bit; col $clog2(RowPixelWidth) bits; no arithmetic wider than these.

## Timing
- Reset values: o_ready=0 during reset, 1 from the first cycle after release (S_COUNT); o_valid=0; o_pixel=0; o_row_end=0; o_err=0; col=0; run_left=0.
- Latency: the LO byte is accepted at edge N; o_valid=1 with the pixel from cycle N+1.
- With i_ready held high, a run of length L occupies exactly L cycles in S_EMIT. o_ready returns to 1 in the cycle after the last pixel handshake.
- Throughput: 3 byte-accept cycles plus L pixel cycles per run, with no idle bubble besides those.
- Backpressure: while i_ready=0, o_pixel, o_valid and o_row_end are held and no counters move.
- The byte input is never accepted while o_valid=1; there is no overlap of byte intake and pixel output.
- An asynchronous RST assertion mid-run aborts immediately. All state returns to reset values, and the partial run is dropped with no o_err.
- o_err is combinational-free: registered, high for exactly one cycle per error event.

## Structure
- Shared package rle_pkg holds:
  - the state enum (S_COUNT, S_HI, S_LO, S_EMIT);
  - SYNC_CODE = 8'h00;
  - MAX_RUN = 255;
  - BYTES_PER_PIXEL = 2.
- The compressor must import the same package so that both ends agree on the format.
- Single module, no sub-module: the FSM, run counter and column counter are tightly coupled.

## Test plan
Bench uses RowPixelWidth=4 unless stated.
- Run bytes 03 12 34, i_ready=1 → pixel 0x1234 on 3 consecutive cycles starting one cycle after the 0x34 accept; o_row_end=0 on all three; o_err=0.
- Runs 02 AB CD, then 02 00 01 → pixels ABCD, ABCD, 0001, 0001; o_row_end on the 4th pixel only; the 0x00 pixel byte is not treated as sync.
- Run 06 55 55 at col=0 → 4 pixels 0x5555, o_row_end on the 4th; o_err pulse one cycle later; next byte accepted in S_COUNT; col=0.
- Stream 01 11 11, then 00 → one pixel, then o_err pulse on sync accept; following run 01 22 22 emitted at col 0. A leading 00 at col 0 → no o_err.
- Run 02 77 88 with i_ready toggled 0,0,1,0,1 → o_pixel held at 0x7788 throughout; exactly 2 handshakes; o_ready=0 until after the second.
- Assert RST low mid-run (after 1 of 5 pixels) → o_valid=0 immediately, all outputs at reset values; after release 01 99 99 → 0x9999 at col 0 with RowPixelWidth=640, o_row_end=0.
